// File: rtl/spdif_subframe_decoder.sv
// Biphase-mark receiver: oversamples the optical line, measures run widths and
// rebuilds 28-bit subframes (slots 4-31) behind a preamble-qualified lock.
module spdif_subframe_decoder #(
    parameter int UI1_MIN        = 8,
    parameter int UI1_MAX        = 24,
    parameter int UI2_MAX        = 40,
    parameter int UI3_MAX        = 57,
    parameter int LOCK_SUBFRAMES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        din,
    output logic [23:0] sample_out,
    output logic        chan_out,
    output logic        block_start_out,
    output logic [2:0]  vuc_out,
    output logic        parity_err_out,
    output logic        valid_out,
    output logic        locked_out
);

    typedef enum logic [1:0] {PW_ERR, PW_1UI, PW_2UI, PW_3UI} pulse_e;
    typedef enum logic [1:0] {S_HUNT, S_PRE, S_DATA} state_e;

    localparam logic [2:0] LOCK_N  = 3'(LOCK_SUBFRAMES);
    localparam logic [5:0] CNT_MAX = 6'd63;

    logic       sync1_q, sync2_q, prev_q;
    logic       edge_w;
    logic [5:0] cnt_q, cnt_d;
    logic       timeout_w;
    pulse_e     cls_q;
    logic       cls_vld_q;

    state_e      state_q;
    logic [1:0]  run_idx_q;
    pulse_e      run1_q, run2_q;
    logic [4:0]  bit_idx_q;
    logic        half_q;
    logic [27:0] shreg_q;
    logic [2:0]  lock_q;
    logic        pre_chan_q, pre_blk_q;

    logic [23:0] sample_q;
    logic        chan_q, blk_q, perr_q, valid_q, locked_q;
    logic [2:0]  vuc_q;

    logic        pre_b_w, pre_m_w, pre_w_w, pre_hit_w;
    logic        err_w, bit_done_w, bit_val_w, last_bit_w;
    logic [27:0] word_w;
    logic [2:0]  lock_inc_w;

    function automatic pulse_e classify(input logic [5:0] w);
        pulse_e c;
        if (w < 6'(UI1_MIN))       c = PW_ERR;
        else if (w <= 6'(UI1_MAX)) c = PW_1UI;
        else if (w <= 6'(UI2_MAX)) c = PW_2UI;
        else if (w <= 6'(UI3_MAX)) c = PW_3UI;
        else                       c = PW_ERR;
        return c;
    endfunction

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_w    = sync2_q ^ prev_q;
    assign timeout_w = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (edge_w) begin
            cnt_d = 6'd1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 6'd1;
        end
    end

    // The run width is classified one cycle after the edge; the FSM consumes it next.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_q     <= 6'd1;
            cls_q     <= PW_ERR;
            cls_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cls_q     <= classify(cnt_q);
            cls_vld_q <= edge_w;
        end
    end

    assign pre_b_w   = (run1_q == PW_1UI) && (run2_q == PW_1UI) && (cls_q == PW_3UI);
    assign pre_m_w   = (run1_q == PW_3UI) && (run2_q == PW_1UI) && (cls_q == PW_1UI);
    assign pre_w_w   = (run1_q == PW_2UI) && (run2_q == PW_1UI) && (cls_q == PW_2UI);
    assign pre_hit_w = pre_b_w || pre_m_w || pre_w_w;

    always_comb begin
        err_w      = timeout_w;
        bit_done_w = 1'b0;
        bit_val_w  = 1'b0;
        if (cls_vld_q) begin
            if (cls_q == PW_ERR) begin
                err_w = 1'b1;
            end else if (state_q == S_PRE) begin
                if (run_idx_q == 2'd3 && !pre_hit_w) err_w = 1'b1;
            end else if (state_q == S_DATA) begin
                if (bit_idx_q == 5'd28) begin
                    // Only a preamble may follow the parity slot.
                    if (cls_q != PW_3UI) err_w = 1'b1;
                end else begin
                    case (cls_q)
                        PW_1UI: begin
                            if (half_q) begin
                                bit_done_w = 1'b1;
                                bit_val_w  = 1'b1;
                            end
                        end
                        PW_2UI: begin
                            if (half_q) err_w = 1'b1;
                            else        bit_done_w = 1'b1;
                        end
                        default: err_w = 1'b1;
                    endcase
                end
            end
        end
    end

    assign word_w     = {bit_val_w, shreg_q[27:1]};
    assign last_bit_w = bit_done_w && (bit_idx_q == 5'd27);
    assign lock_inc_w = (lock_q == LOCK_N) ? lock_q : lock_q + 3'd1;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= S_HUNT;
            run_idx_q  <= 2'd0;
            run1_q     <= PW_ERR;
            run2_q     <= PW_ERR;
            bit_idx_q  <= 5'd0;
            half_q     <= 1'b0;
            shreg_q    <= '0;
            lock_q     <= 3'd0;
            pre_chan_q <= 1'b0;
            pre_blk_q  <= 1'b0;
            sample_q   <= '0;
            chan_q     <= 1'b0;
            blk_q      <= 1'b0;
            vuc_q      <= '0;
            perr_q     <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (err_w) begin
                state_q  <= S_HUNT;
                half_q   <= 1'b0;
                lock_q   <= 3'd0;
                locked_q <= 1'b0;
            end else if (cls_vld_q) begin
                case (state_q)
                    S_HUNT: begin
                        if (cls_q == PW_3UI) begin
                            state_q   <= S_PRE;
                            run_idx_q <= 2'd1;
                        end
                    end
                    S_PRE: begin
                        case (run_idx_q)
                            2'd1: begin
                                run1_q    <= cls_q;
                                run_idx_q <= 2'd2;
                            end
                            2'd2: begin
                                run2_q    <= cls_q;
                                run_idx_q <= 2'd3;
                            end
                            default: begin
                                state_q    <= S_DATA;
                                bit_idx_q  <= 5'd0;
                                half_q     <= 1'b0;
                                pre_chan_q <= pre_w_w;
                                pre_blk_q  <= pre_b_w;
                            end
                        endcase
                    end
                    S_DATA: begin
                        if (bit_idx_q == 5'd28) begin
                            state_q   <= S_PRE;
                            run_idx_q <= 2'd1;
                        end else if (bit_done_w) begin
                            shreg_q   <= word_w;
                            bit_idx_q <= bit_idx_q + 5'd1;
                            half_q    <= 1'b0;
                            if (last_bit_w) begin
                                lock_q   <= lock_inc_w;
                                locked_q <= (lock_inc_w == LOCK_N);
                                if (lock_inc_w == LOCK_N) begin
                                    valid_q  <= 1'b1;
                                    sample_q <= word_w[23:0];
                                    vuc_q    <= {word_w[24], word_w[25], word_w[26]};
                                    perr_q   <= ^word_w;
                                    chan_q   <= pre_chan_q;
                                    blk_q    <= pre_blk_q;
                                end
                            end
                        end else begin
                            half_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_HUNT;
                endcase
            end
        end
    end

    assign sample_out      = sample_q;
    assign chan_out        = chan_q;
    assign block_start_out = blk_q;
    assign vuc_out         = vuc_q;
    assign parity_err_out  = perr_q;
    assign valid_out       = valid_q;
    assign locked_out      = locked_q;

endmodule

// File: tb/tb_spdif_subframe_decoder.sv
// Scoreboard bench: a subframe-level line model predicts strobes and lock state.
`timescale 1ns/1ps
module tb_spdif_subframe_decoder;

    localparam int LOCK = 4;
    localparam int PRE_B = 0;
    localparam int PRE_M = 1;
    localparam int PRE_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] sample_out;
    logic        chan_out, block_start_out, parity_err_out, valid_out, locked_out;
    logic [2:0]  vuc_out;

    spdif_subframe_decoder dut (
        .clk_in          (clk),
        .rst_in_n        (rst_n),
        .din             (din),
        .sample_out      (sample_out),
        .chan_out        (chan_out),
        .block_start_out (block_start_out),
        .vuc_out         (vuc_out),
        .parity_err_out  (parity_err_out),
        .valid_out       (valid_out),
        .locked_out      (locked_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] s;
        logic        ch;
        logic        blk;
        logic [2:0]  vuc;
        logic        perr;
        int          k;
    } exp_t;

    exp_t q[$];
    exp_t pend_item;
    bit   pend = 1'b0;
    int   done_cnt = 0;
    bit   jitter = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after the falling edge, away from the DUT's active edge.
    initial begin
        forever begin
            exp_t e;
            logic [30:0] got, want;
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk({sample_out, chan_out, block_start_out, vuc_out, parity_err_out, valid_out, locked_out} == '0,
                    "reset_outputs",
                    {sample_out, chan_out, block_start_out, vuc_out, parity_err_out, valid_out, locked_out}, 0);
            end else if (valid_out) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_strobe", sample_out, 0);
                end else begin
                    e    = q.pop_front();
                    got  = {sample_out, chan_out, block_start_out, vuc_out, parity_err_out, locked_out};
                    want = {e.s, e.ch, e.blk, e.vuc, e.perr, 1'b1};
                    chk(got == want, "strobe_fields", got, want);
                    chk(cyc == e.k + 3, "strobe_latency", cyc, e.k + 3);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each line transition ends the previous run; a pending clean subframe completes here.
    task automatic toggle();
        din = ~din;
        if (pend) begin
            pend = 1'b0;
            if (done_cnt < LOCK) done_cnt++;
            if (done_cnt == LOCK) begin
                pend_item.k = cyc + 1;
                q.push_back(pend_item);
            end
        end
    endtask

    task automatic hold(input int w);
        repeat (w) @(negedge clk);
    endtask

    function automatic int ui_w(input int n);
        int b;
        b = (n == 1) ? 16 : (n == 2) ? 33 : 49;
        if (jitter) b = b + int'($urandom_range(10)) - 5;
        return b;
    endfunction

    task automatic pulse(input int n);
        toggle();
        hold(ui_w(n));
    endtask

    task automatic lock_watch(input int kk, input bit lk, input int hi_off, input string name);
        if (lk) begin
            while (cyc < kk + hi_off) @(negedge clk);
            chk(locked_out === 1'b1, {name, "_before"}, locked_out, 1);
        end
        while (cyc < kk + hi_off + 1) @(negedge clk);
        chk(locked_out === 1'b0, name, locked_out, 0);
    endtask

    task automatic send_subframe(input int kind, input logic [23:0] s, input logic [2:0] vuc,
                                 input bit pflip, input int glitch_bit, input int stall, input int rst_at);
        int          runs[4];
        logic [27:0] w;
        int          kk;
        bit          lk;
        chk(locked_out === logic'(done_cnt == LOCK), "lock_state", locked_out, done_cnt == LOCK);
        case (kind)
            PRE_B:   runs = '{3, 1, 1, 3};
            PRE_M:   runs = '{3, 3, 1, 1};
            default: runs = '{3, 2, 1, 2};
        endcase
        w = {(^{s, vuc}) ^ pflip, vuc[0], vuc[1], vuc[2], s};
        if (rst_at > 0) begin
            fork
                begin
                    hold(rst_at);
                    rst_n = 1'b0;
                    hold(6);
                    rst_n = 1'b1;
                end
            join_none
        end
        toggle();
        if (stall > 0) begin
            kk = cyc + 1;
            lk = (done_cnt == LOCK);
            fork lock_watch(kk, lk, 64, "stall_lock_drop"); join_none
        end
        hold(ui_w(runs[0]) + stall);
        for (int r = 1; r < 4; r++) pulse(runs[r]);
        for (int b = 0; b < 28; b++) begin
            if (b == glitch_bit) begin
                toggle();
                hold(5);
                kk = cyc + 1;
                lk = (done_cnt == LOCK);
                fork lock_watch(kk, lk, 2, "glitch_lock_drop"); join_none
            end
            if (w[b]) begin
                pulse(1);
                pulse(1);
            end else begin
                pulse(2);
            end
        end
        if (glitch_bit >= 0 || stall > 0 || rst_at > 0) begin
            done_cnt = 0;
            pend     = 1'b0;
        end else begin
            pend_item.s    = s;
            pend_item.ch   = (kind == PRE_W);
            pend_item.blk  = (kind == PRE_B);
            pend_item.vuc  = vuc;
            pend_item.perr = pflip;
            pend           = 1'b1;
        end
    endtask

    task automatic send_clean(input int i, input bit pflip);
        if (i % 2 == 1) send_subframe(PRE_W, 24'h123456, 3'b001, pflip, -1, 0, 0);
        else            send_subframe(PRE_B, 24'hA5A5A5, 3'b001, pflip, -1, 0, 0);
    endtask

    task automatic send_random(input int i, input int rst_at);
        int kind;
        kind = (i % 2 == 1) ? PRE_W : (($urandom_range(1) == 1) ? PRE_B : PRE_M);
        send_subframe(kind, 24'($urandom), 3'($urandom_range(7)), $urandom_range(5) == 0, -1, 0, rst_at);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            din = 1'($urandom_range(1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        hold(100);

        for (int i = 0; i < 10; i++) send_clean(i, i == 7);

        send_subframe(PRE_B, 24'hA5A5A5, 3'b001, 1'b0, 12, 0, 0);
        for (int i = 1; i < 7; i++) send_clean(i, 1'b0);

        send_subframe(PRE_W, 24'h123456, 3'b001, 1'b0, -1, 80, 0);
        for (int i = 0; i < 6; i++) send_clean(i, 1'b0);

        jitter = 1'b1;
        for (int i = 0; i < 8; i++) send_random(i, (i == 4) ? 400 : 0);
        for (int i = 0; i < 6; i++) send_random(i, 0);

        toggle();
        hold(20);
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
